// File: rtl/serial_tx_unit.sv
// serial_tx_unit
//   Framed serial transmitter fed by the read/transmit flow controller.
//   A word is captured from dataIn on sampleData (IDLE only). A rising edge
//   on txData then sends: start bit (0), DATA_WIDTH data bits LSB first,
//   an optional parity bit, and a stop bit (1). Each bit is held for
//   CLKS_PER_BIT cycles. txDone pulses for one cycle once the stop bit ends.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   active     : block enable; low aborts a frame and idles the line
//   sampleData : load dataIn into the holding register
//   txData     : transmit request, rising-edge sensitive
//   dataIn     : parallel word to send
//   txOut      : serial line, idle high
//   txDone     : one-cycle pulse after the stop bit
//   txBusy     : high while a frame is on the line
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | line idle high, accepts capture and start
// S_START  | driving start bit
// S_DATA   | driving data bits, LSB first
// S_PARITY | driving parity bit (PARITY != 0 only)
// S_STOP   | driving stop bit
// S_DONE   | txDone high for one cycle; a new start is accepted here

module serial_tx_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  sampleData,
  input  logic                  txData,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  txOut,
  output logic                  txDone,
  output logic                  txBusy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  par_q, par_d;
  logic                  tx_prev_q, tx_prev_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] word;

  assign start   = txData & ~tx_prev_q;
  assign bit_end = (cyc_q == CYC_LAST);
  // Same-edge capture and start sends the incoming word, not the stale one.
  assign word    = sampleData ? dataIn : hold_q;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    par_d     = par_q;
    tx_prev_d = txData;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    done_d    = done_q;

    if (!active) begin
      state_d  = S_IDLE;
      cyc_d    = '0;
      bit_d    = '0;
      tx_out_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_d = 1'b0;
          if (state_q == S_IDLE && sampleData) hold_d = dataIn;
          if (start) begin
            state_d  = S_START;
            shreg_d  = word;
            // Even parity: bit equals XOR of data; odd parity inverts it.
            par_d    = (^word) ^ (PARITY == 2);
            cyc_d    = '0;
            bit_d    = '0;
            tx_out_d = 1'b0;
            busy_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_d    = '0;
            state_d  = S_DATA;
            tx_out_d = shreg_q[0];
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc_d   = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (PARITY != 0) begin
                state_d  = S_PARITY;
                tx_out_d = par_q;
              end else begin
                state_d  = S_STOP;
                tx_out_d = 1'b1;
              end
            end else begin
              bit_d    = bit_q + 1'b1;
              tx_out_d = shreg_d[0];
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cyc_d    = '0;
            state_d  = S_STOP;
            tx_out_d = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc_d    = '0;
            state_d  = S_DONE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          tx_out_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      hold_q    <= '0;
      par_q     <= 1'b0;
      tx_prev_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      par_q     <= par_d;
      tx_prev_q <= tx_prev_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign txOut  = tx_out_q;
  assign txDone = done_q;
  assign txBusy = busy_q;

endmodule

// File: tb/tb_serial_tx_unit.sv
// Bench for serial_tx_unit. Four instances share one stimulus:
//   u0: CLKS_PER_BIT=4, no parity   u1: 4, even parity
//   u2: 4, odd parity               u3: CLKS_PER_BIT=1, even parity
// A frame-level model predicts every output on every cycle; directed
// literal checks pin the model to hand-worked frames.

module tb_serial_tx_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       sampleData;
  logic       txData;
  logic [7:0] dataIn;
  logic [3:0] tx_out, tx_done, tx_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_tx_unit #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .active(active), .sampleData(sampleData),
    .txData(txData), .dataIn(dataIn),
    .txOut(tx_out[0]), .txDone(tx_done[0]), .txBusy(tx_busy[0]));
  serial_tx_unit #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .active(active), .sampleData(sampleData),
    .txData(txData), .dataIn(dataIn),
    .txOut(tx_out[1]), .txDone(tx_done[1]), .txBusy(tx_busy[1]));
  serial_tx_unit #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .active(active), .sampleData(sampleData),
    .txData(txData), .dataIn(dataIn),
    .txOut(tx_out[2]), .txDone(tx_done[2]), .txBusy(tx_busy[2]));
  serial_tx_unit #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(1)) u3 (
    .clk(clk), .reset(reset), .active(active), .sampleData(sampleData),
    .txData(txData), .dataIn(dataIn),
    .txOut(tx_out[3]), .txDone(tx_done[3]), .txBusy(tx_busy[3]));

  function automatic int cpb_of(input int u);
    return (u == 3) ? 1 : 4;
  endfunction

  function automatic int par_of(input int u);
    case (u)
      0: return 0;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int flen(input int u);
    return (10 + ((par_of(u) != 0) ? 1 : 0)) * cpb_of(u);
  endfunction

  // Bit idx of the frame: start, 8 data LSB first, optional parity, stop.
  function automatic bit frame_bit(input logic [7:0] d, input int par, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par != 0 && idx == 9) return (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  // Model: m_k counts cycles since the accepting edge; k==F is the done cycle.
  bit         m_on[4];
  int         m_k[4];
  logic [7:0] m_data[4];
  logic [7:0] m_hold[4];
  bit         m_prev;
  bit         m_rise;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev = 1'b0;
      for (int u = 0; u < 4; u++) begin
        m_on[u] = 1'b0; m_k[u] = 0; m_hold[u] = 8'h00; m_data[u] = 8'h00;
      end
    end else begin
      m_rise = txData && !m_prev;
      m_prev = txData;
      for (int u = 0; u < 4; u++) begin
        if (!active) begin
          m_on[u] = 1'b0;
        end else if (m_on[u] && m_k[u] < flen(u)) begin
          m_k[u]++;
        end else begin
          if (!m_on[u] && sampleData) m_hold[u] = dataIn;
          if (m_rise) begin
            m_on[u] = 1'b1;
            m_k[u] = 0;
            m_data[u] = sampleData ? dataIn : m_hold[u];
          end else begin
            m_on[u] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      bit e_tx, e_busy, e_done;
      e_busy = m_on[u] && m_k[u] < flen(u);
      e_done = m_on[u] && m_k[u] == flen(u);
      e_tx = e_busy ? frame_bit(m_data[u], par_of(u), m_k[u] / cpb_of(u)) : 1'b1;
      chk($sformatf("u%0d txOut", u), int'(tx_out[u]), int'(e_tx));
      chk($sformatf("u%0d txBusy", u), int'(tx_busy[u]), int'(e_busy));
      chk($sformatf("u%0d txDone", u), int'(tx_done[u]), int'(e_done));
    end
  end

  // Recording of outputs relative to the accepting edge E (index k = after E+k).
  bit rec_tx[4][64];
  bit rec_busy[4][64];
  bit rec_done[4][64];
  int rec_idx = 64;
  int done_cnt[4];

  task automatic tick();
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      if (rec_idx < 64) begin
        rec_tx[u][rec_idx] = tx_out[u];
        rec_busy[u][rec_idx] = tx_busy[u];
        rec_done[u][rec_idx] = tx_done[u];
      end
      done_cnt[u] += int'(tx_done[u]);
    end
    if (rec_idx < 64) rec_idx++;
  endtask

  task automatic start_frame(input bit samp, input logic [7:0] d);
    txData = 1'b1; sampleData = samp; dataIn = d;
    rec_idx = 0;
    tick();
    sampleData = 1'b0;
  endtask

  function automatic int busy_count(input int u);
    int n = 0;
    for (int k = 0; k < rec_idx; k++) n += int'(rec_busy[u][k]);
    return n;
  endfunction

  function automatic int done_count(input int u);
    int n = 0;
    for (int k = 0; k < rec_idx; k++) n += int'(rec_done[u][k]);
    return n;
  endfunction

  function automatic int first_done(input int u);
    for (int k = 0; k < rec_idx; k++) if (rec_done[u][k]) return k;
    return -1;
  endfunction

  function automatic int rec_bit(input int u, input int j);
    return int'(rec_tx[u][j * cpb_of(u) + cpb_of(u) / 2]);
  endfunction

  function automatic int rec_byte(input int u);
    int b = 0;
    for (int j = 0; j < 8; j++) b |= rec_bit(u, j + 1) << j;
    return b;
  endfunction

  int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int d0[4];

  initial begin
    reset = 1'b1; active = 1'b0; sampleData = 1'b0; txData = 1'b0; dataIn = 8'h00;
    #1 reset = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d reset txOut", u), int'(tx_out[u]), 1);
      chk($sformatf("u%0d reset txBusy", u), int'(tx_busy[u]), 0);
      chk($sformatf("u%0d reset txDone", u), int'(tx_done[u]), 0);
    end
    tick(); tick();
    reset = 1'b1; active = 1'b1;
    tick();

    // 0xA5 captured, then sent on each parity flavour
    sampleData = 1'b1; dataIn = 8'hA5; tick(); sampleData = 1'b0; tick();
    start_frame(1'b0, 8'h00);
    repeat (49) tick();
    txData = 1'b0;
    for (int j = 0; j < 10; j++) chk($sformatf("a5 bit%0d", j), rec_bit(0, j), exp_a5[j]);
    chk("a5 u0 busy cycles", busy_count(0), 40);
    chk("a5 u0 done edge", first_done(0), 40);
    chk("a5 u0 done pulses", done_count(0), 1);
    chk("a5 u1 busy cycles", busy_count(1), 44);
    chk("a5 u1 done edge", first_done(1), 44);
    chk("a5 even parity", rec_bit(1, 9), 0);
    chk("a5 odd parity", rec_bit(2, 9), 1);
    chk("a5 u3 busy cycles", busy_count(3), 11);
    chk("a5 u3 done edge", first_done(3), 11);
    chk("a5 u3 parity", rec_bit(3, 9), 0);
    tick();

    // 0x00: odd parity must be 1, even parity 0
    sampleData = 1'b1; dataIn = 8'h00; tick(); sampleData = 1'b0; tick();
    start_frame(1'b0, 8'h00);
    repeat (49) tick();
    txData = 1'b0;
    chk("00 odd parity", rec_bit(2, 9), 1);
    chk("00 even parity", rec_bit(1, 9), 0);
    tick();

    // Bypass capture; sample and re-trigger during the frame are ignored
    start_frame(1'b1, 8'h3C);
    repeat (9) tick();
    sampleData = 1'b1; dataIn = 8'hFF; tick(); sampleData = 1'b0; dataIn = 8'h00;
    repeat (9) tick();
    txData = 1'b0; tick(); txData = 1'b1;
    repeat (28) tick();
    txData = 1'b0;
    chk("bypass data", rec_byte(0), 8'h3C);
    chk("bypass done edge", first_done(0), 40);
    chk("busy retrigger done pulses", done_count(0), 1);
    tick();
    start_frame(1'b0, 8'h00);
    repeat (49) tick();
    txData = 1'b0;
    chk("hold kept 3C", rec_byte(0), 8'h3C);
    tick();

    // txData held high for 100 cycles: one frame per unit
    for (int u = 0; u < 4; u++) d0[u] = done_cnt[u];
    start_frame(1'b0, 8'h00);
    repeat (99) tick();
    txData = 1'b0;
    for (int u = 0; u < 4; u++)
      chk($sformatf("u%0d held-high done pulses", u), done_cnt[u] - d0[u], 1);
    tick();

    // Abort with active low for one edge at E+13
    start_frame(1'b0, 8'h00);
    repeat (12) tick();
    for (int u = 0; u < 4; u++) d0[u] = done_cnt[u];
    active = 1'b0;
    tick();
    active = 1'b1;
    chk("abort pre busy", int'(rec_busy[0][12]), 1);
    chk("abort txOut", int'(rec_tx[0][13]), 1);
    chk("abort txBusy", int'(rec_busy[0][13]), 0);
    repeat (49) tick();
    for (int u = 0; u < 3; u++)
      chk($sformatf("u%0d abort no done", u), done_cnt[u] - d0[u], 0);
    txData = 1'b0; tick();
    start_frame(1'b0, 8'h00);
    repeat (49) tick();
    txData = 1'b0;
    chk("post-abort busy cycles", busy_count(0), 40);
    chk("post-abort done edge", first_done(0), 40);
    tick();

    // Asynchronous reset mid-DATA, between clock edges
    start_frame(1'b0, 8'h00);
    repeat (15) tick();
    #2 reset = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d async rst txOut", u), int'(tx_out[u]), 1);
      chk($sformatf("u%0d async rst txBusy", u), int'(tx_busy[u]), 0);
      chk($sformatf("u%0d async rst txDone", u), int'(tx_done[u]), 0);
    end
    txData = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    start_frame(1'b0, 8'h00);
    repeat (49) tick();
    txData = 1'b0;
    chk("post-reset busy cycles", busy_count(0), 40);
    chk("post-reset done edge", first_done(0), 40);
    chk("post-reset data", rec_byte(0), 8'h00);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_unit.md
# serial_tx_unit

Serial transmitter that sits directly downstream of the read/transmit flow controller. It consumes the controller's `sampleData` and `txData` strobes: it captures a parallel word from the memory/data path, then shifts it out as a framed serial stream. It returns the one-cycle `txDone` pulse that the controller waits on before going idle.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (≥1).
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held (≥1).
- `PARITY`, 0: 0 = no parity bit, 1 = even parity, 2 = odd parity.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (`reset`=0 resets immediately; release is synchronous to `clk`).
- `active`  input  1  block enable; low aborts any frame.
- `sampleData`  input  1  capture `dataIn` into holding register.
- `txData`  input  1  transmit request; rising edge starts a frame.
- `dataIn`  input  DATA_WIDTH  parallel word to send.
- `txOut`  output  1  serial line, idle high.
- `txDone`  output  1  one-cycle pulse after stop bit completes.
- `txBusy`  output  1  high while a frame is in progress.

## Operation
- All outputs are registered. Reset values: `txOut`=1, `txDone`=0, `txBusy`=0, holding register=0, `txData` edge-detect register=0, state=IDLE, counters=0.
- Frame format: start bit (0), then DATA_WIDTH data bits LSB first, then the parity bit (only if PARITY≠0), then the stop bit (1). The parity bit makes the count of ones across data+parity even (PARITY=1) or odd (PARITY=2).
- Capture: on an edge with `active`=1, `sampleData`=1 and state IDLE, the holding register loads `dataIn`. `sampleData` in any other state is ignored.
- Start: a rising edge of `txData` means `txData`=1 and the registered previous value is 0. If this occurs in IDLE with `active`=1, the block goes to START. Holding `txData` high never retriggers a frame.
- If `sampleData` and the `txData` rising edge arrive on the same edge, the frame carries the current `dataIn` (bypass). The holding register is loaded as well.
- A `txData` rising edge outside IDLE is ignored and not queued.
- States and transitions:
  - IDLE → START on a start condition.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (or STOP when PARITY=0) after DATA_WIDTH bits.
  - PARITY → STOP after one bit period.
  - STOP → DONE after CLKS_PER_BIT cycles.
  - DONE → IDLE after one cycle.
- `txBusy`=1 in START, DATA, PARITY and STOP. `txDone`=1 only in DONE.
- Bit counter width is clog2(DATA_WIDTH+1). The cycle counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. With CLKS_PER_BIT=1 each bit lasts exactly one cycle.
- Abort: `active`=0 on any clock edge forces state IDLE, `txOut`=1 and `txBusy`=0 at that edge, with no `txDone` pulse. The holding register is retained.
- Asynchronous `reset` assertion mid-frame immediately forces all reset values, including `txOut`=1.

## Timing
- Let edge E be the edge that detects the start condition. `txOut` becomes 0 and `txBusy` becomes 1 after E.
- Each frame bit is driven for exactly CLKS_PER_BIT cycles, back to back.
- Frame length F = (DATA_WIDTH + 2 + (PARITY≠0)) × CLKS_PER_BIT cycles.
- `txBusy` falls and `txDone` rises at edge E+F. `txDone` falls at E+F+1, when the block is back in IDLE.
- Minimum spacing between frames: a new `txData` rising edge is accepted from edge E+F+1 onward.
- `txOut` glitch-free: it changes only on bit boundaries.

## Test plan
- Defaults (8, 4, 0). Reset release, then `sampleData` pulse with `dataIn`=0xA5, then `txData` rise → `txOut` bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles. `txBusy` high for 40 cycles, `txDone` high 1 cycle at E+40.
- PARITY=1 with 0xA5 → parity bit 0, frame 44 cycles. PARITY=2 with 0xA5 → parity bit 1. PARITY=2 with 0x00 → parity bit 1.
- `sampleData` with `dataIn`=0x3C and `txData` rise on the same edge → transmitted data 0x3C. A later `sampleData` with 0xFF during the frame → ignored, holding register stays 0x3C.
- `txData` held high for 100 cycles → exactly one frame and one `txDone` pulse. A `txData` rise issued while busy → no second frame.
- `active` dropped for 1 cycle at E+13 → `txOut`=1 and `txBusy`=0 at that edge, no `txDone`. A new `txData` rise with `active`=1 starts a clean frame.
- `reset` asserted low asynchronously mid-DATA, between clock edges → `txOut`=1, `txBusy`=0, `txDone`=0 immediately. After release, a normal frame completes in 40 cycles.
